ccff_chain_loader: RTL and testbench

// - Bitstream loader upstream of the switch/connection-block configuration chain. It drives the chain head and the prog_clk gate enable.
// - Takes host config words over valid/ready and serialises them MSB-first onto ccff_head, one bit per enabled prog_clk edge.
// - Captures the bits leaving the chain at ccff_tail and repacks them into readback words. Reloading a chain therefore returns its previous contents.

---
 rtl/ccff_loader_pkg.sv | 17 +
 rtl/ccff_chain_loader_if.sv | 26 ++
 rtl/ccff_rb_packer.sv | 67 ++++++
 rtl/ccff_chain_loader.sv | 126 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
//   state_e  : loader FSM states
//   ceil_div : integer ceiling division, used for host word counts
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host-side bundle for the chain loader: config words in, readback words out.
//   cfg_data/cfg_valid/cfg_ready : host -> loader config word handshake
//   rb_data/rb_valid/rb_ready    : loader -> host readback word handshake
// master = host side, slave = loader side.
interface ccff_chain_loader_if #(
  parameter int unsigned WORD_W = 8
);

  logic [WORD_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [WORD_W-1:0] rb_data;
  logic              rb_valid;
  logic              rb_ready;

  modport master (
    output cfg_data, cfg_valid, rb_ready,
    input  cfg_ready, rb_data, rb_valid
  );

  modport slave (
    input  cfg_data, cfg_valid, rb_ready,
    output cfg_ready, rb_data, rb_valid
  );

endinterface

// File: rtl/ccff_rb_packer.sv
// Collects bits leaving the chain tail into host readback words.
//   prog_clk, pReset : clock, async active-high reset
//   capture, cap_bit : one chain bit captured this cycle
//   last             : this capture is the final bit of the chain
//   rb_data/rb_valid/rb_ready : readback word handshake (first bit at MSB)
//   rb_col_full      : collector cannot take a capture this cycle
//   rb_idle          : nothing left to hand over after this edge
module ccff_rb_packer #(
  parameter int unsigned WORD_W = 8
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              capture,
  input  logic              cap_bit,
  input  logic              last,
  input  logic              rb_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  output logic              rb_col_full,
  output logic              rb_idle
);

  localparam int unsigned CNT_W = $clog2(WORD_W + 1);

  logic [WORD_W-1:0] rb_col;
  logic [CNT_W-1:0]  col_cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              col_full;
  logic              xfer;

  // A full collector moves to rb_data whenever the output slot is free or being freed.
  assign xfer        = col_full && (!rb_valid || rb_ready);
  // Blocking only when the word cannot move this cycle, so word boundaries cost no bubble.
  assign rb_col_full = col_full && !xfer;
  assign rb_idle     = !col_full && (!rb_valid || rb_ready);
  assign cnt_nxt     = xfer ? CNT_W'(1) : col_cnt + CNT_W'(1);

  // Collector and output register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      rb_col   <= '0;
      col_cnt  <= '0;
      col_full <= 1'b0;
      rb_data  <= '0;
      rb_valid <= 1'b0;
    end else begin
      if (xfer) begin
        // Left-align a short final word; its low bits come out as zero.
        rb_data  <= rb_col << (CNT_W'(WORD_W) - col_cnt);
        rb_valid <= 1'b1;
      end else if (rb_ready) begin
        rb_valid <= 1'b0;
      end

      if (capture) begin
        rb_col   <= xfer ? {{(WORD_W-1){1'b0}}, cap_bit} : {rb_col[WORD_W-2:0], cap_bit};
        col_cnt  <= cnt_nxt;
        col_full <= last || (cnt_nxt == CNT_W'(WORD_W));
      end else if (xfer) begin
        rb_col   <= '0;
        col_cnt  <= '0;
        col_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads host config words MSB-first into the configuration chain and
// repacks the bits pushed out of the chain tail into readback words.
//   prog_clk, pReset : programming clock, async active-high reset
//   start            : one-cycle pulse, begins a load when idle
//   bus (slave)      : cfg word in / readback word out handshakes
//   ccff_head        : serial bit into chain head (valid while chain_clk_en)
//   ccff_tail        : serial bit from chain tail
//   chain_clk_en     : fabric prog_clk gate; chain shifts at next rising edge
//   busy             : load or drain in progress
//   done             : one-cycle pulse after load and readback complete
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 40,
  parameter int unsigned WORD_W    = 8
) (
  input  logic               prog_clk,
  input  logic               pReset,
  input  logic               start,
  ccff_chain_loader_if.slave bus,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               chain_clk_en,
  output logic               busy,
  output logic               done
);

  localparam int unsigned N_WORDS   = ceil_div(CHAIN_LEN, WORD_W);
  localparam int unsigned LAST_BITS = CHAIN_LEN - (N_WORDS - 1) * WORD_W;
  localparam int unsigned SC_W      = $clog2(CHAIN_LEN + 1);
  localparam int unsigned BL_W      = $clog2(WORD_W + 1);
  localparam int unsigned WL_W      = $clog2(N_WORDS + 1);

  state_e            state;
  state_e            state_nxt;
  logic [SC_W-1:0]   shift_cnt;
  logic [WL_W-1:0]   words_left;
  logic [BL_W-1:0]   bits_left;
  logic [WORD_W-1:0] wbuf;
  logic              shift;
  logic              load_word;
  logic              last_cap;
  logic              rb_col_full;
  logic              rb_idle;

  assign shift        = (state == LOAD) && (bits_left != '0) && !rb_col_full;
  // Ready during the last bit of the current word keeps the chain shifting every cycle.
  assign bus.cfg_ready = (state == LOAD) && (words_left != '0) &&
                         ((bits_left == '0) || ((bits_left == BL_W'(1)) && shift));
  assign load_word    = bus.cfg_valid && bus.cfg_ready;
  assign last_cap     = (shift_cnt == SC_W'(CHAIN_LEN - 1));
  assign chain_clk_en = shift;
  assign ccff_head    = shift && wbuf[WORD_W-1];

  // State register.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LOAD;
      LOAD:    if (shift_cnt == SC_W'(CHAIN_LEN)) state_nxt = DRAIN;
      // A word being accepted this edge no longer counts as pending.
      DRAIN:   if (rb_idle) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      LOAD, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default:     ;
    endcase
  end

  // Word buffer and shift/word counters.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      shift_cnt  <= '0;
      words_left <= '0;
      bits_left  <= '0;
      wbuf       <= '0;
    end else if ((state == IDLE) && start) begin
      shift_cnt  <= '0;
      words_left <= WL_W'(N_WORDS);
      bits_left  <= '0;
    end else begin
      if (shift) begin
        wbuf      <= wbuf << 1;
        bits_left <= bits_left - BL_W'(1);
        if (shift_cnt != SC_W'(CHAIN_LEN)) shift_cnt <= shift_cnt + SC_W'(1);
      end
      // A new word overrides the shift of the previous word's last bit.
      if (load_word) begin
        wbuf       <= bus.cfg_data;
        bits_left  <= (words_left == WL_W'(1)) ? BL_W'(LAST_BITS) : BL_W'(WORD_W);
        words_left <= words_left - WL_W'(1);
      end
    end
  end

  ccff_rb_packer #(
    .WORD_W (WORD_W)
  ) u_rb_packer (
    .prog_clk    (prog_clk),
    .pReset      (pReset),
    .capture     (shift),
    .cap_bit     (ccff_tail),
    .last        (last_cap),
    .rb_ready    (bus.rb_ready),
    .rb_data     (bus.rb_data),
    .rb_valid    (bus.rb_valid),
    .rb_col_full (rb_col_full),
    .rb_idle     (rb_idle)
  );

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: a 40-bit and a 12-bit chain, each with a shift-register
// tail model; expectations come from word/bit arithmetic on the host words and
// on a snapshot of the chain taken before each load.
module tb_ccff_chain_loader;

  localparam int unsigned W  = 8;
  localparam int unsigned LA = 40;
  localparam int unsigned LB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic rst_a, start_a, head_a, tail_a, en_a, busy_a, done_a;
  logic rst_b, start_b, head_b, tail_b, en_b, busy_b, done_b;

  ccff_chain_loader_if #(.WORD_W(W)) ifa ();
  ccff_chain_loader_if #(.WORD_W(W)) ifb ();

  ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(W)) dut_a (
    .prog_clk(clk), .pReset(rst_a), .start(start_a), .bus(ifa),
    .ccff_head(head_a), .ccff_tail(tail_a), .chain_clk_en(en_a),
    .busy(busy_a), .done(done_a)
  );

  ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(W)) dut_b (
    .prog_clk(clk), .pReset(rst_b), .start(start_b), .bus(ifb),
    .ccff_head(head_b), .ccff_tail(tail_b), .chain_clk_en(en_b),
    .busy(busy_b), .done(done_b)
  );

  // Chain models: shift on enabled edges, tail is the oldest bit.
  logic [LA-1:0] chain_a, init_a;
  logic [LB-1:0] chain_b, init_b;
  logic          init_req;

  always @(posedge clk) begin
    if (init_req)  chain_a <= init_a;
    else if (en_a) chain_a <= {chain_a[LA-2:0], head_a};
    if (init_req)  chain_b <= init_b;
    else if (en_b) chain_b <= {chain_b[LB-2:0], head_b};
  end
  assign tail_a = chain_a[LA-1];
  assign tail_b = chain_b[LB-1];

  logic [W-1:0] words [5];

  logic         s_ready, s_en, s_head, s_rbv, s_busy, s_done;
  logic [W-1:0] s_rbd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int sel, input logic st, input logic v, input logic [W-1:0] d, input logic rr);
    if (sel == 0) begin
      start_a = st; ifa.cfg_valid = v; ifa.cfg_data = d; ifa.rb_ready = rr;
    end else begin
      start_b = st; ifb.cfg_valid = v; ifb.cfg_data = d; ifb.rb_ready = rr;
    end
  endtask

  task automatic set_rst(input int sel, input logic r);
    if (sel == 0) rst_a = r;
    else          rst_b = r;
  endtask

  task automatic smp(input int sel);
    if (sel == 0) begin
      s_ready = ifa.cfg_ready; s_en = en_a; s_head = head_a; s_rbv = ifa.rb_valid;
      s_rbd = ifa.rb_data; s_busy = busy_a; s_done = done_a;
    end else begin
      s_ready = ifb.cfg_ready; s_en = en_b; s_head = head_b; s_rbv = ifb.rb_valid;
      s_rbd = ifb.rb_data; s_busy = busy_b; s_done = done_b;
    end
  endtask

  function automatic logic [63:0] outs_vec();
    return 64'({s_en, s_head, s_ready, s_rbv, s_rbd, s_busy, s_done});
  endfunction

  // One load of words[] into instance sel, cycle by cycle.
  task automatic run_load(input int sel, input int gap_len, input int rbstall, input int rst_at,
                          input int exp_stall, input bit use_const, input logic [63:0] rb_const);
    int            L, nw, idx, cyc, wi;
    int            en_cnt, first_en, last_en, first_acc, done_cnt, done_cyc, last_hs, gap_cnt, rb_first, rb_n;
    logic [LA-1:0] snap;
    logic [63:0]   exp_head, obs_head, exp_rb, obs_rb;
    logic [W-1:0]  held, d;
    logic          v, rr, st, busy_seen, stall_ok;

    L    = (sel == 0) ? LA : LB;
    nw   = (L + W - 1) / W;
    snap = (sel == 0) ? chain_a : LA'(chain_b);
    exp_head = '0; exp_rb = '0; obs_head = '0; obs_rb = '0;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < W; j++) begin
        idx = k * W + j;
        if (idx < L) exp_head = {exp_head[62:0], words[k][W-1-j]};
        exp_rb = {exp_rb[62:0], (idx < L) ? snap[L-1-idx] : 1'b0};
      end
    end

    wi = 0; en_cnt = 0; first_en = -1; last_en = -1; first_acc = -1; done_cnt = 0;
    done_cyc = -1000; last_hs = -1; gap_cnt = 0; rb_first = -1; rb_n = 0;
    held = '0; busy_seen = 1'b0; stall_ok = 1'b1;

    for (cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      st = (cyc == 0) || (cyc == 6);
      v  = (wi < nw);
      d  = (wi < nw) ? words[wi] : '0;
      rr = 1'b1;
      drv(sel, st, v, d, rr);
      #1 smp(sel);
      if (gap_len > 0 && wi == 2 && gap_cnt < gap_len && (gap_cnt > 0 || s_ready)) begin
        v = 1'b0;
        gap_cnt++;
      end
      if (rbstall > 0 && rb_first < 0 && s_rbv) begin
        rb_first = cyc;
        held     = s_rbd;
      end
      if (rb_first >= 0 && cyc < rb_first + rbstall) rr = 1'b0;
      drv(sel, st, v, d, rr);
      #1 smp(sel);
      if (s_en) begin
        if (first_en < 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
        obs_head = {obs_head[62:0], s_head};
        if (en_cnt == 1) busy_seen = s_busy;
      end
      if (v && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        wi++;
      end
      if (s_rbv && rr) begin
        obs_rb = {obs_rb[55:0], s_rbd};
        rb_n++;
        last_hs = cyc;
      end
      if (s_rbv && !rr && s_rbd !== held) stall_ok = 1'b0;
      if (s_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rst_at > 0 && en_cnt == rst_at) break;
      if (done_cnt > 0 && cyc >= done_cyc + 2) break;
    end

    if (rst_at > 0) begin
      set_rst(sel, 1'b1);
      #1 smp(sel);
      chk("rst_async_outputs", outs_vec(), 64'd0);
      @(negedge clk);
      smp(sel);
      chk("rst_next_cycle_outputs", outs_vec(), 64'd0);
      drv(sel, 1'b0, 1'b0, '0, 1'b1);
      set_rst(sel, 1'b0);
      return;
    end

    drv(sel, 1'b0, 1'b0, '0, 1'b1);
    chk("en_count", 64'(en_cnt), 64'(L));
    chk("head_seq", obs_head, exp_head);
    chk("rb_words", 64'(rb_n), 64'(nw));
    chk("rb_seq", obs_rb, exp_rb);
    if (use_const) chk("rb_reload_words", obs_rb, rb_const);
    chk("first_en_latency", 64'(first_en - first_acc), 64'd1);
    chk("stall_cycles", 64'(last_en - first_en + 1 - L), 64'(exp_stall));
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("done_after_last_rb", 64'(done_cyc - last_hs), 64'd1);
    chk("busy_in_load", 64'(busy_seen), 64'd1);
    chk("busy_after_done", 64'(s_busy), 64'd0);
    if (rbstall > 0) chk("rb_stable_in_stall", 64'(stall_ok), 64'd1);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    drv(0, 1'b0, 1'b0, '0, 1'b1);
    drv(1, 1'b0, 1'b0, '0, 1'b1);
    init_a   = LA'({$urandom(), $urandom()});
    init_b   = LB'($urandom());
    init_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    init_req = 1'b0;
    smp(0); chk("reset_outputs_a", outs_vec(), 64'd0);
    smp(1); chk("reset_outputs_b", outs_vec(), 64'd0);
    rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    // Directed words, random prior chain contents.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hF0; words[3] = 8'h0F; words[4] = 8'h81;
    run_load(0, 0, 0, 0, 0, 1'b0, 64'd0);

    // Reload with zeros returns the previous words.
    for (int i = 0; i < 5; i++) words[i] = 8'h00;
    run_load(0, 0, 0, 0, 0, 1'b1, 64'hA5_3C_F0_0F_81);

    // Host gap of 3 cycles before the third word.
    for (int i = 0; i < 5; i++) words[i] = W'($urandom());
    run_load(0, 3, 0, 0, 3, 1'b0, 64'd0);

    // Readback consumer stalled for 10 cycles.
    for (int i = 0; i < 5; i++) words[i] = W'($urandom());
    run_load(0, 0, 10, 0, 3, 1'b0, 64'd0);

    // Reset partway through, then a clean load.
    for (int i = 0; i < 5; i++) words[i] = W'($urandom());
    run_load(0, 0, 0, 17, 0, 1'b0, 64'd0);
    for (int i = 0; i < 5; i++) words[i] = W'($urandom());
    run_load(0, 0, 0, 0, 0, 1'b0, 64'd0);

    // 12-bit chain: partial final word.
    words[0] = 8'hAB; words[1] = 8'hCD; words[2] = 8'h00; words[3] = 8'h00; words[4] = 8'h00;
    run_load(1, 0, 0, 0, 0, 1'b0, 64'd0);
    words[0] = W'($urandom()); words[1] = W'($urandom());
    run_load(1, 0, 0, 0, 0, 1'b1, 64'hAB_C0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
